// File: rtl/alu.sv
// N-bit adder/subtractor for the kwanCPU datapath: tri-state bus driver,
// live carry/zero flags and a flags register for conditional jumps.
module alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         su,
  input  logic         eo_,
  input  logic         fi_,
  output logic [N-1:0] bus,
  output logic         cf,
  output logic         zf,
  output logic         cf_q,
  output logic         zf_q
);

  logic [N:0]   sum;
  logic [N-1:0] r;
  logic         cf_d;
  logic         zf_d;

  // Subtraction is a + ~b + 1, so carry-out set means "no borrow".
  always_comb begin
    sum = {1'b0, a} + {1'b0, b ^ {N{su}}} + {{N{1'b0}}, su};
    r   = sum[N-1:0];
  end

  assign cf  = sum[N];
  assign zf  = (r == '0);
  assign bus = eo_ ? {N{1'bz}} : r;

  always_comb begin
    cf_d = cf_q;
    zf_d = zf_q;
    if (!fi_) begin
      cf_d = cf;
      zf_d = zf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      cf_q <= cf_d;
      zf_q <= zf_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected values from an
// arithmetic reference model, a monitor pops and compares on each strobe.
module tb_alu;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         su;
  logic         eo_;
  logic         fi_;
  wire  [N-1:0] bus;
  logic         cf;
  logic         zf;
  logic         cf_q;
  logic         zf_q;

  // Bench-side probe driver: when the DUT floats the bus this value shows through.
  logic         drv_en  = 1'b0;
  logic [N-1:0] drv_val = '0;
  assign bus = drv_en ? drv_val : {N{1'bz}};

  alu #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .su   (su),
    .eo_  (eo_),
    .fi_  (fi_),
    .bus  (bus),
    .cf   (cf),
    .zf   (zf),
    .cf_q (cf_q),
    .zf_q (zf_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         chk_bus;
    logic [N-1:0] bus;
    logic         cf;
    logic         zf;
    logic         cf_q;
    logic         zf_q;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_req  = 1'b0;
  logic m_cf_q   = 1'b0;
  logic m_zf_q   = 1'b0;

  // Reference: plain unsigned integer arithmetic modulo 2^N.
  function automatic void model(input logic [N-1:0] ai, input logic [N-1:0] bi,
                                input logic sui, output logic [N-1:0] r,
                                output logic c, output logic z);
    int unsigned ia  = ai;
    int unsigned ib  = bi;
    int unsigned mod = 1 << N;
    int unsigned res;
    if (!sui) begin
      res = ia + ib;
      c   = (res >= mod);
    end else begin
      res = ia + mod - ib;
      c   = (ia >= ib);
    end
    r = N'(res % mod);
    z = (r == '0);
  endfunction

  task automatic cmp(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge chk_req) begin : monitor
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      if (e.chk_bus) cmp({e.name, ".bus"}, bus, e.bus);
      cmp({e.name, ".cf"},   N'(cf),   N'(e.cf));
      cmp({e.name, ".zf"},   N'(zf),   N'(e.zf));
      cmp({e.name, ".cf_q"}, N'(cf_q), N'(e.cf_q));
      cmp({e.name, ".zf_q"}, N'(zf_q), N'(e.zf_q));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] ai, input logic [N-1:0] bi,
                               input logic sui, input logic eoi, input logic fii);
    a   = ai;
    b   = bi;
    su  = sui;
    eo_ = eoi;
    fi_ = fii;
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t         e;
    logic [N-1:0] r;
    logic         c;
    logic         z;
    model(a, b, su, r, c, z);
    e.name    = name;
    e.chk_bus = !eo_ || drv_en;
    e.bus     = eo_ ? drv_val : r;
    e.cf      = c;
    e.zf      = z;
    e.cf_q    = m_cf_q;
    e.zf_q    = m_zf_q;
    sb.push_back(e);
    chk_req = 1'b1;
    #1;
    chk_req = 1'b0;
  endtask

  task automatic setReset(input logic v);
    rst = v;
    if (v) begin
      m_cf_q = 1'b0;
      m_zf_q = 1'b0;
    end
    #1;
  endtask

  // One rising edge; the model captures the pre-edge flags when loading.
  task automatic tickClock(input string name);
    logic [N-1:0] r;
    logic         c;
    logic         z;
    logic         load;
    model(a, b, su, r, c, z);
    load = !fi_ && !rst;
    @(posedge clk);
    if (load) begin
      m_cf_q = c;
      m_zf_q = z;
    end
    #1;
    checkOutput(name);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("reset_zero_add");

    @(negedge clk);
    setReset(1'b0);

    applyStimulus(8'd34, 8'd0, 1'b0, 1'b0, 1'b1);   checkOutput("add_34_0");
    applyStimulus(8'd34, 8'd12, 1'b0, 1'b0, 1'b1);  checkOutput("add_34_12");
    applyStimulus(8'd34, 8'd12, 1'b1, 1'b0, 1'b1);  checkOutput("sub_34_12");
    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b1); checkOutput("add_wrap");
    applyStimulus(8'd12, 8'd34, 1'b1, 1'b0, 1'b1);  checkOutput("sub_borrow");
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);  checkOutput("add_80_80");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);  checkOutput("add_ff_01");
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);  checkOutput("sub_0_ff");

    // Floating bus: each probe value must show through untouched.
    applyStimulus(8'h5A, 8'h11, 1'b0, 1'b1, 1'b1);
    drv_en  = 1'b1;
    drv_val = {N{1'b1}};
    #1;
    checkOutput("tristate_probe_ones");
    drv_val = {N{1'b0}};
    #1;
    checkOutput("tristate_probe_zeros");
    drv_en = 1'b0;
    applyStimulus(8'h5A, 8'h11, 1'b0, 1'b0, 1'b1);  checkOutput("tristate_release");

    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    tickClock("flags_load_80_80");
    setReset(1'b1);
    checkOutput("flags_async_reset");
    applyStimulus(8'd5, 8'd5, 1'b1, 1'b0, 1'b0);
    tickClock("flags_reset_dominates");
    setReset(1'b0);
    tickClock("flags_load_5_5");
    applyStimulus(8'd1, 8'd2, 1'b1, 1'b0, 1'b1);
    tickClock("flags_hold");

    setReset(1'b1);
    checkOutput("midrun_reset");
    setReset(1'b0);
    checkOutput("midrun_release");
    tickClock("midrun_hold_after_release");
    applyStimulus(8'd5, 8'd5, 1'b1, 1'b0, 1'b0);
    tickClock("midrun_reload");

    for (int i = 0; i < 60; i++) begin
      applyStimulus(N'($urandom), N'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0), 1'($urandom));
      checkOutput($sformatf("rand%0d", i));
      tickClock($sformatf("rand%0d_clk", i));
    end

    for (int t = 0; t < 10 && sb.size() != 0; t++) #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
